// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: type encodings, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package imm_gen_pipe_pkg;

    // Default datapath width; the generator also supports 64.
    localparam int XLEN_DEFAULT = 32;

    // Width of the immediate format selector.
    localparam int TYPE_W = 3;

    // Immediate format encodings.
    localparam logic [TYPE_W-1:0] IMM_R  = 3'd0;
    localparam logic [TYPE_W-1:0] IMM_I  = 3'd1;
    localparam logic [TYPE_W-1:0] IMM_S  = 3'd2;
    localparam logic [TYPE_W-1:0] IMM_B  = 3'd3;
    localparam logic [TYPE_W-1:0] IMM_J  = 3'd4;
    localparam logic [TYPE_W-1:0] IMM_U  = 3'd5;
    localparam logic [TYPE_W-1:0] IMM_Z  = 3'd6;
    localparam logic [TYPE_W-1:0] IMM_SH = 3'd7;

endpackage

// File: rtl/imm_gen_pipe_fmt.sv
// Maps (inst, imm_type) to an XLEN-wide immediate; reusable by any stage.
// Latency: combinational.
// Backpressure: none (no handshake).
module imm_gen_pipe_fmt
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int TYPE_W = imm_gen_pipe_pkg::TYPE_W
) (
    input  logic [31:0]       inst,
    input  logic [TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]   imm
);

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Build the 32-bit form of each format, then sign- or zero-extend to XLEN.
    always_comb begin
        imm = '0;
        case (imm_type)
            TYPE_W'(IMM_R):  imm = '0;
            TYPE_W'(IMM_I):  imm = XLEN'($signed({{20{inst[31]}}, inst[31:20]}));
            TYPE_W'(IMM_S):  imm = XLEN'($signed({{20{inst[31]}}, inst[31:25], inst[11:7]}));
            TYPE_W'(IMM_B):  imm = XLEN'($signed({{19{inst[31]}}, inst[31], inst[7],
                                                   inst[30:25], inst[11:8], 1'b0}));
            TYPE_W'(IMM_J):  imm = XLEN'($signed({{11{inst[31]}}, inst[31], inst[19:12],
                                                   inst[20], inst[30:21], 1'b0}));
            TYPE_W'(IMM_U):  imm = XLEN'($signed({inst[31:12], 12'h000}));
            TYPE_W'(IMM_Z):  imm = XLEN'(inst[19:15]);
            TYPE_W'(IMM_SH): begin
                // RV64 shift amounts carry one extra bit.
                if (XLEN == 64) imm = XLEN'(inst[25:20]);
                else            imm = XLEN'(inst[24:20]);
            end
            default:         imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (M main, K skid); optional IMM_TARGET_EN adds pc+imm.
// Latency: 1 cycle from accept to out_valid; strictly FIFO.
// Backpressure: in_ready drops while K holds a token; flush/rst empty both entries.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int TYPE_W = imm_gen_pipe_pkg::TYPE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [TYPE_W-1:0] in_imm_type,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
`ifdef IMM_TARGET_EN
    output logic [XLEN-1:0]   out_target,
`endif
    output logic [31:0]       out_inst
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
`ifdef IMM_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } token_t;

    // Encoding is {K.valid, M.valid}, so the valid bits fall straight out of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t          state, state_nxt;
    token_t          m_tok, k_tok, new_tok;
    logic [XLEN-1:0] new_imm;
    logic            m_vld, k_vld;
    logic            accept, pop;
    logic            m_load_new, m_load_k, k_load_new;

    imm_gen_pipe_fmt #(
        .XLEN   (XLEN),
        .TYPE_W (TYPE_W)
    ) u_fmt (
        .inst     (in_inst),
        .imm_type (in_imm_type),
        .imm      (new_imm)
    );

    assign new_tok.inst = in_inst;
    assign new_tok.imm  = new_imm;
`ifdef IMM_TARGET_EN
    // Target is formed ahead of the register so latency stays at one cycle.
    assign new_tok.target = in_pc + new_imm;
    assign out_target     = m_tok.target;
`else
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

    assign m_vld     = state[0];
    assign k_vld     = state[1];
    assign in_ready  = ~rst & ~k_vld;
    assign out_valid = m_vld;
    assign out_imm   = m_tok.imm;
    assign out_inst  = m_tok.inst;

    // Flush drops the same-cycle input outright.
    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next occupancy and register load steering; flush overrides everything.
    always_comb begin
        state_nxt  = state;
        m_load_new = 1'b0;
        m_load_k   = 1'b0;
        k_load_new = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt  = ST_ONE;
                    m_load_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    m_load_new = 1'b1;
                end else if (accept) begin
                    state_nxt  = ST_TWO;
                    k_load_new = 1'b1;
                end else if (pop) begin
                    state_nxt  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_nxt = ST_ONE;
                    m_load_k  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // Token storage; cleared on reset so outputs read zero while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tok <= '0;
            k_tok <= '0;
        end else begin
            if (m_load_new)    m_tok <= new_tok;
            else if (m_load_k) m_tok <= k_tok;
            if (k_load_new)    k_tok <= new_tok;
        end
    end

endmodule
